// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-side pointer, full/almost-full and level control for an async FIFO
//
// Ports:
//   clk_a        write-domain clock (rising edge)
//   rst          asynchronous active-high reset (shared with the read domain)
//   wen_a        producer write request
//   rd_ptr_gray  Gray read pointer from clk_b domain (synchronised here, sampled nowhere else)
//   wr_ptr_gray  registered Gray write pointer handed to the read domain
//   w_addr       RAM write address
//   mem_we       RAM write strobe (accepted write, combinational)
//   full         registered full flag
//   almost_full  registered almost-full flag (free entries <= AF_THRESH)
//   wr_level     registered occupancy as seen from clk_a (0..DEPTH)
//   overflow     asserted during a cycle whose write is rejected because full
//
// Build option: define FIFO_WR_LEVEL_EN to implement wr_level/almost_full;
// otherwise both outputs are tied to 0 and the level datapath is absent.

module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int AF_THRESH  = 8
) (
    input  logic                  clk_a,
    input  logic                  rst,
    input  logic                  wen_a,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  mem_we,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    logic [ADDR_WIDTH:0] wr_bin;
    logic [ADDR_WIDTH:0] next_bin;
    logic [ADDR_WIDTH:0] next_gray;
    logic [ADDR_WIDTH:0] rq1;
    logic [ADDR_WIDTH:0] rq2;
    logic [ADDR_WIDTH:0] full_match;
    logic [ADDR_WIDTH:0] level_next;
    logic                full_next;
    logic                af_next;

    // The reset term keeps the RAM strobe quiet while rst is held, independent
    // of the (already reset) full flag.
    assign mem_we   = wen_a & ~full & ~rst;
    assign overflow = wen_a & full & ~rst;
    assign w_addr   = wr_bin[ADDR_WIDTH-1:0];

    assign next_bin  = wr_bin + {{ADDR_WIDTH{1'b0}}, mem_we};
    assign next_gray = next_bin ^ (next_bin >> 1);

    // In Gray code, "one full lap ahead" means the two MSBs differ and the
    // remaining bits match.
    assign full_match = {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]};
    assign full_next  = (next_gray == full_match);

`ifdef FIFO_WR_LEVEL_EN
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - AF_THRESH);

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Modulo subtraction over the wrap bit yields 0..DEPTH directly.
    assign level_next = next_bin - gray2bin(rq2);
    assign af_next    = (level_next >= AF_LEVEL);
`else
    // No level datapath in this build; the threshold term folds to a constant 0.
    assign level_next = '0;
    assign af_next    = 1'b0 && (AF_THRESH > 0);
`endif

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            wr_bin      <= '0;
            wr_ptr_gray <= '0;
            rq1         <= '0;
            rq2         <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            wr_bin      <= next_bin;
            wr_ptr_gray <= next_gray;
            rq1         <= rd_ptr_gray;
            rq2         <= rq1;
            full        <= full_next;
            almost_full <= af_next;
            wr_level    <= level_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - directed self-checking bench for fifo_wr_ctrl (ADDR_WIDTH=4, AF_THRESH=4)

module tb_fifo_wr_ctrl;

`ifdef FIFO_WR_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic       clk_a;
    logic       rst;
    logic       wen_a;
    logic [4:0] rd_ptr_gray;
    logic [4:0] wr_ptr_gray;
    logic [3:0] w_addr;
    logic       mem_we;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       overflow;

    int n_vec;
    int n_err;

    // Gray codes of 1..16, written out by hand.
    logic [4:0] gray_tab [16] = '{5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
                                   5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};

    fifo_wr_ctrl #(
        .ADDR_WIDTH (4),
        .AF_THRESH  (4)
    ) dut (
        .clk_a       (clk_a),
        .rst         (rst),
        .wen_a       (wen_a),
        .rd_ptr_gray (rd_ptr_gray),
        .wr_ptr_gray (wr_ptr_gray),
        .w_addr      (w_addr),
        .mem_we      (mem_we),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    initial clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [4:0] wr_cnt;
    logic [4:0] rd_val;

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        wen_a       = 1'b1;
        rd_ptr_gray = '0;

        // Reset with a write request pending.
        repeat (3) @(posedge clk_a);
        #1;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_w_addr", 32'(w_addr), 0);
        chk("rst_wr_gray", 32'(wr_ptr_gray), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_level", 32'(wr_level), 0);
        chk("rst_ovf", 32'(overflow), 0);

        @(negedge clk_a);
        rst   = 1'b0;
        wen_a = 1'b0;
        @(posedge clk_a);
        #1;
        chk("idle_wr_gray", 32'(wr_ptr_gray), 0);

        // Fill 16 entries with the read pointer parked at 0.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_a);
            wen_a = 1'b1;
            #1;
            chk("fill_w_addr", 32'(w_addr), 32'(i));
            chk("fill_mem_we", 32'(mem_we), 1);
            @(posedge clk_a);
            #1;
            chk("fill_wr_gray", 32'(wr_ptr_gray), 32'(gray_tab[i]));
            chk("fill_full", 32'(full), (i == 15) ? 1 : 0);
            chk("fill_afull", 32'(almost_full), (LVL_EN && i >= 11) ? 1 : 0);
            chk("fill_level", 32'(wr_level), LVL_EN ? 32'(i + 1) : 0);
        end

        // Writes against a full FIFO are rejected.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_a);
            wen_a = 1'b1;
            #1;
            chk("ovf_pulse", 32'(overflow), 1);
            chk("ovf_mem_we", 32'(mem_we), 0);
            @(posedge clk_a);
            #1;
            chk("ovf_wr_gray", 32'(wr_ptr_gray), 24);
            chk("ovf_full", 32'(full), 1);
        end
        @(negedge clk_a);
        wen_a = 1'b0;
        #1;
        chk("ovf_clear", 32'(overflow), 0);

        // One read: full clears on the third edge after the pointer moves.
        @(negedge clk_a);
        rd_ptr_gray = 5'd1;
        @(posedge clk_a);
        #1;
        chk("drain_full_e1", 32'(full), 1);
        @(posedge clk_a);
        #1;
        chk("drain_full_e2", 32'(full), 1);
        @(posedge clk_a);
        #1;
        chk("drain_full_e3", 32'(full), 0);
        chk("drain_level", 32'(wr_level), LVL_EN ? 15 : 0);
        chk("drain_afull", 32'(almost_full), LVL_EN ? 1 : 0);

        // Mid-operation reset clears pointer state without waiting for a clock.
        @(negedge clk_a);
        rst         = 1'b1;
        rd_ptr_gray = '0;
        #1;
        chk("midrst_wr_gray", 32'(wr_ptr_gray), 0);
        chk("midrst_w_addr", 32'(w_addr), 0);
        chk("midrst_level", 32'(wr_level), 0);
        chk("midrst_afull", 32'(almost_full), 0);
        @(negedge clk_a);
        rst = 1'b0;

        // 40 writes, read side trailing two entries; pointer wraps 31 -> 0.
        wr_cnt = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_a);
            wen_a = 1'b1;
            if (n >= 2) begin
                rd_val      = wr_cnt - 5'd1;
                rd_ptr_gray = to_gray(rd_val);
            end
            #1;
            chk("wrap_w_addr", 32'(w_addr), 32'(wr_cnt[3:0]));
            chk("wrap_mem_we", 32'(mem_we), 1);
            @(posedge clk_a);
            #1;
            wr_cnt = wr_cnt + 5'd1;
            chk("wrap_wr_gray", 32'(wr_ptr_gray), 32'(to_gray(wr_cnt)));
            if (n == 31) chk("wrap_to_zero", 32'(wr_ptr_gray), 0);
            chk("wrap_full_w", 32'(full), 0);
            @(negedge clk_a);
            wen_a = 1'b0;
            @(posedge clk_a);
            @(posedge clk_a);
            #1;
            chk("wrap_level", 32'(wr_level), LVL_EN ? ((n == 0) ? 1 : 2) : 0);
            chk("wrap_full_s", 32'(full), 0);
            chk("wrap_afull", 32'(almost_full), 0);
        end
        chk("wrap_end_gray", 32'(wr_ptr_gray), 12);
        chk("wrap_end_addr", 32'(w_addr), 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
